// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width, reset
// defaults and the fetch FSM encoding.
package if_fetch_stage_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013; // addi x0,x0,0

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/if_fetch_stage_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module if_id_reg
   import if_fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            bubble,
   input  logic [XLEN-1:0] load_pc,
   input  logic [XLEN-1:0] load_instr,
   output logic [XLEN-1:0] pc_id,
   output logic [XLEN-1:0] instr_id,
   output logic            valid_id
);

   // load and bubble are never both high; neither means hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_id    <= '0;
         instr_id <= NOP_INSTR;
         valid_id <= 1'b0;
      end else if (load) begin
         pc_id    <= load_pc;
         instr_id <= load_instr;
         valid_id <= 1'b1;
      end else if (bubble) begin
         pc_id    <= '0;
         instr_id <= NOP_INSTR;
         valid_id <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem
// handshake and feeds the IF/ID register with stall/bubble/redirect handling.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_if,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] pc_id,
   output logic [XLEN-1:0] instr_id,
   output logic            valid_id,
   output fetch_state_t    state_dbg
);

   // Handshake: a request is accepted on a cycle with imem_req & imem_gnt; the
   // address is sampled only then. Exactly one imem_rvalid follows, at least one
   // cycle later, and no new request is raised until it has been consumed.

   fetch_state_t    state, state_next;
   logic            kill, kill_next;
   logic [XLEN-1:0] pc, pc_next;
   logic [XLEN-1:0] hold_buf;
   logic            hold_capture;
   logic            deliver_wait, deliver_hold, load, bubble;
   logic [XLEN-1:0] load_instr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         kill  <= 1'b0;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         kill  <= kill_next;
         pc    <= pc_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hold_buf <= '0;
      else if (hold_capture)
         hold_buf <= imem_rdata;
   end

   always_comb begin
      state_next   = state;
      kill_next    = kill;
      hold_capture = 1'b0;
      case (state)
         FETCH: begin
            // A grant coinciding with a redirect fetched the old PC: mark it stale.
            if (imem_gnt) begin
               state_next = WAIT;
               kill_next  = redirect;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               kill_next = 1'b0;
               if (!redirect && !kill && stall_if) begin
                  state_next   = HOLD;
                  hold_capture = 1'b1;
               end else begin
                  state_next = FETCH;
               end
            end else if (redirect) begin
               kill_next = 1'b1;
            end
         end
         HOLD: begin
            if (redirect || !stall_if)
               state_next = FETCH;
         end
         default: begin
            state_next = FETCH;
            kill_next  = 1'b0;
         end
      endcase

      if (redirect)
         pc_next = redirect_pc;
      else if (load)
         pc_next = pc + XLEN'(4);
      else
         pc_next = pc;
   end

   always_comb begin
      imem_req     = (state == FETCH) && !rst;
      deliver_wait = (state == WAIT) && imem_rvalid && !kill && !redirect && !stall_if;
      deliver_hold = (state == HOLD) && !redirect && !stall_if;
      load         = deliver_wait || deliver_hold;
      load_instr   = deliver_hold ? hold_buf : imem_rdata;
      // Without a new instruction, an unstalled ID must not see the old one twice.
      bubble       = redirect || (!load && !stall_if);
   end

   assign imem_addr = pc;
   assign state_dbg = state;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .bubble     (bubble),
      .load_pc    (pc),
      .load_instr (load_instr),
      .pc_id      (pc_id),
      .instr_id   (instr_id),
      .valid_id   (valid_id)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a memory model answers grants, a monitor
// checks every grant address and every IF/ID delivery against expected queues.
`timescale 1ns/1ps
module tb_if_fetch_stage;
   import if_fetch_stage_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         stall_if, redirect;
   logic [31:0]  redirect_pc;
   logic         imem_req, imem_gnt, imem_rvalid;
   logic [31:0]  imem_addr, imem_rdata;
   logic [31:0]  pc_id, instr_id;
   logic         valid_id;
   fetch_state_t state_dbg;

   int checks = 0;
   int errors = 0;
   int rlat   = 1;

   logic [63:0] exp_q[$];
   logic [31:0] exp_addr_q[$];

   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall_if    (stall_if),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc_id       (pc_id),
      .instr_id    (instr_id),
      .valid_id    (valid_id),
      .state_dbg   (state_dbg)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h0010_0113;
         32'h0000_0008: return 32'h0020_8193;
         32'h0000_000C: return 32'h0031_8213;
         32'h0000_0010: return 32'h0041_8293;
         32'h0000_0100: return 32'h0aa0_0313;
         32'h0000_0104: return 32'h0ab0_0313;
         32'h0000_0200: return 32'h0bb0_0393;
         32'h0000_0300: return 32'h0cc0_0413;
         32'h0000_0304: return 32'h0cd0_0413;
         32'hFFFF_FFFC: return 32'h0dd0_0493;
         default:       return 32'hdead_0013;
      endcase
   endfunction

   // Memory: samples a grant mid-cycle, answers rlat cycles later.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      pend        = 1'b0;
      pend_addr   = '0;
      pend_cnt    = 0;
      forever begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = rlat;
         end
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(pend_addr);
               pend        = 1'b0;
            end
         end
      end
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic push_out(input logic [31:0] pc, input logic [31:0] instr);
      exp_q.push_back({pc, instr});
   endtask

   task automatic monitor();
      logic [63:0] e;
      logic [31:0] ea;
      forever begin
         @(negedge clk);
         if (!rst && valid_id) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_delivery: got pc %h instr %h expected none", pc_id, instr_id);
            end else begin
               e = exp_q.pop_front();
               check32("pc_id", pc_id, e[63:32]);
               check32("instr_id", instr_id, e[31:0]);
            end
         end
         if (imem_req && imem_gnt) begin
            if (exp_addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: got addr %h expected none", imem_addr);
            end else begin
               ea = exp_addr_q.pop_front();
               check32("grant_addr", imem_addr, ea);
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_grant(input logic [31:0] a);
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         step();
         ok = imem_req && imem_gnt && (imem_addr == a);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_grant: got no grant expected grant at %h within 50 cycles", a);
      end
   endtask

   task automatic wait_rvalid();
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         step();
         ok = imem_rvalid;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_rvalid: got no response expected one within 50 cycles");
      end
   endtask

   task automatic wait_valid_pc(input logic [31:0] a);
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         step();
         ok = valid_id && (pc_id == a);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_valid_pc: got no delivery expected pc_id %h within 50 cycles", a);
      end
   endtask

   initial begin
      stall_if    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_gnt    = 1'b1;
      fork
         monitor();
      join_none

      // Reset values
      step();
      step();
      check32("reset_pc_id", pc_id, 32'h0);
      check32("reset_instr_id", instr_id, NOP);
      check1("reset_valid_id", valid_id, 1'b0);
      check1("reset_imem_req", imem_req, 1'b0);
      check32("reset_imem_addr", imem_addr, 32'h0);

      // Streaming fetch from RESET_PC, then stall into HOLD at 0x8
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h4);
      exp_addr_q.push_back(32'h8);
      exp_addr_q.push_back(32'hC);
      exp_addr_q.push_back(32'h10);
      push_out(32'h0, 32'h0050_0093);
      push_out(32'h4, 32'h0010_0113);
      push_out(32'h8, 32'h0020_8193);
      push_out(32'hC, 32'h0031_8213);
      rst = 1'b0;
      wait_valid_pc(32'h0);
      step();
      check1("alt_cycle_bubble", valid_id, 1'b0);
      wait_grant(32'h8);
      step();
      stall_if = 1'b1;
      step();
      check1("hold_no_req_1", imem_req, 1'b0);
      check1("hold_valid_1", valid_id, 1'b0);
      step();
      check1("hold_no_req_2", imem_req, 1'b0);
      check1("hold_valid_2", valid_id, 1'b0);
      step();
      stall_if = 1'b0;
      check1("hold_no_req_3", imem_req, 1'b0);
      rlat = 2;

      // Redirect while the 0x10 response is outstanding
      exp_addr_q.push_back(32'h100);
      push_out(32'h100, 32'h0aa0_0313);
      wait_grant(32'h10);
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      check1("killed_resp_no_req", imem_req, 1'b0);
      step();
      check1("after_kill_req", imem_req, 1'b1);
      check32("after_kill_addr", imem_addr, 32'h100);

      // Redirect together with rvalid and stall_if
      exp_addr_q.push_back(32'h104);
      exp_addr_q.push_back(32'h200);
      push_out(32'h200, 32'h0bb0_0393);
      wait_valid_pc(32'h100);
      wait_rvalid();
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      stall_if    = 1'b1;
      step();
      redirect = 1'b0;
      stall_if = 1'b0;
      check1("redir_rvalid_req", imem_req, 1'b1);
      check32("redir_rvalid_addr", imem_addr, 32'h200);
      check1("redir_rvalid_bubble", valid_id, 1'b0);

      // Grant withheld, then redirect while requesting
      exp_addr_q.push_back(32'h300);
      exp_addr_q.push_back(32'h304);
      push_out(32'h300, 32'h0cc0_0413);
      wait_rvalid();
      imem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check1("no_gnt_req", imem_req, 1'b1);
         check32("no_gnt_addr", imem_addr, 32'h204);
      end
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      step();
      redirect = 1'b0;
      imem_gnt = 1'b1;
      rlat     = 1;
      check1("redir_fetch_req", imem_req, 1'b1);
      check32("redir_fetch_addr", imem_addr, 32'h300);

      // Reset while waiting for the 0x304 response
      wait_valid_pc(32'h300);
      rlat = 3;
      step();
      rst      = 1'b1;
      imem_gnt = 1'b0;
      #1;
      check32("midreset_pc_id", pc_id, 32'h0);
      check32("midreset_instr_id", instr_id, NOP);
      check1("midreset_valid_id", valid_id, 1'b0);
      check1("midreset_req", imem_req, 1'b0);
      check32("midreset_addr", imem_addr, 32'h0);
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h4);
      exp_addr_q.push_back(32'hFFFF_FFFC);
      exp_addr_q.push_back(32'h0);
      push_out(32'h0, 32'h0050_0093);
      push_out(32'hFFFF_FFFC, 32'h0dd0_0493);
      push_out(32'h0, 32'h0050_0093);
      step();
      rst = 1'b0;
      step();
      check1("stray_rvalid_req", imem_req, 1'b1);
      check1("stray_rvalid_valid", valid_id, 1'b0);
      step();
      imem_gnt = 1'b1;
      rlat     = 1;
      check32("post_reset_addr", imem_addr, 32'h0);

      // Redirect on a granted fetch, then PC wrap at the top of memory
      wait_valid_pc(32'h0);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      check1("stale_grant_waits", imem_req, 1'b0);
      wait_valid_pc(32'hFFFF_FFFC);
      step();
      imem_gnt = 1'b0;
      wait_valid_pc(32'h0);
      repeat (3) step();
      check1("final_req", imem_req, 1'b1);
      check32("final_addr_wrap", imem_addr, 32'h4);

      check32("exp_q_empty", 32'(exp_q.size()), 32'h0);
      check32("exp_addr_q_empty", 32'(exp_addr_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
